// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control FSM: opcode/funct values,
// state encoding, control-field encodings and the control-output bundle.
package multicycle_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned WAIT_W  = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [STATE_W-1:0] S_IF         = 5'd0;
  localparam logic [STATE_W-1:0] S_ID         = 5'd1;
  localparam logic [STATE_W-1:0] S_EX_MEMADDR = 5'd2;
  localparam logic [STATE_W-1:0] S_EX_XORI    = 5'd3;
  localparam logic [STATE_W-1:0] S_EX_RALU    = 5'd4;
  localparam logic [STATE_W-1:0] S_EX_BR      = 5'd5;
  localparam logic [STATE_W-1:0] S_EX_JR      = 5'd6;
  localparam logic [STATE_W-1:0] S_MEM_LW     = 5'd7;
  localparam logic [STATE_W-1:0] S_MEM_SW     = 5'd8;
  localparam logic [STATE_W-1:0] S_WB_LW      = 5'd9;
  localparam logic [STATE_W-1:0] S_WB_IMM     = 5'd10;
  localparam logic [STATE_W-1:0] S_WB_R       = 5'd11;
  localparam logic [STATE_W-1:0] S_HALT       = 5'd12;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [2:0] SRCB_IMM  = 3'd1;
  localparam logic [2:0] SRCB_REG  = 3'd2;
  localparam logic [2:0] SRCB_FOUR = 3'd3;
  localparam logic [2:0] SRCB_JR   = 3'd4;

  localparam logic [1:0] PCSRC_ALU  = 2'd1;
  localparam logic [1:0] PCSRC_JUMP = 2'd2;

  localparam logic [3:0] BR_BEQ = 4'd1;
  localparam logic [3:0] BR_BNE = 4'd2;

  typedef struct packed {
    logic       mem_req;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       mem_in;
    logic       mem_we;
    logic       ir_we;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic       dst;
    logic       reg_in;
    logic       reg_we;
    logic [3:0] branch;
    logic       jal;
  } ctrl_t;

  // States that hold a memory access open until mem_ready.
  function automatic logic is_mem_state(logic [STATE_W-1:0] s);
    return (s == S_IF) || (s == S_MEM_LW) || (s == S_MEM_SW);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive unanswered memory cycles; hit_c_o flags the cycle in
// which an access that is still waiting would reach WAIT_MAX waits.
module mc_wait_timer
  import multicycle_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  output logic hit_c_o
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Any answered or non-memory cycle clears, so every access starts from zero.
  assign cnt_d   = wait_i ? cnt_q + WAIT_W'(1) : '0;
  assign hit_c_o = wait_i && (cnt_q == WAIT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the MIPS subset: sequences IF/ID/EX/MEM/WB,
// counts retired instructions and halts on memory timeout.
// Build option: MULTICYCLE_CTRL_TRAP_EN halts on undecoded instructions.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PC_WE,
  output logic [1:0]       PCSrc,
  output logic             MemIn,
  output logic             Mem_WE,
  output logic             IR_WE,
  output logic             ALUSrcA,
  output logic [2:0]       ALUSrcB,
  output logic [2:0]       ALUop,
  output logic             Dst,
  output logic             RegIn,
  output logic             Reg_WE,
  output logic [3:0]       Branch,
  output logic             JAL,
  output logic [CNT_W-1:0] retired,
  output logic             timeout,
  output logic [4:0]       state_o
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [2:0]         rop_q;
  logic [2:0]         rop_d;
  logic [CNT_W-1:0]   retired_q;
  logic               timeout_q;
  logic               timeout_d;
  logic               wait_c;
  logic               expire_c;
  logic               illegal_c;
  logic [5:0]         opcode_c;
  logic [5:0]         funct_c;
  logic               unused_c;
  ctrl_t              ctrl_c;

  assign opcode_c = instruction[31:26];
  assign funct_c  = instruction[5:0];
  assign unused_c = ^instruction[25:6];
  assign wait_c   = is_mem_state(state_q) && !mem_ready;

  mc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wait_i (wait_c),
    .hit_c_o(expire_c)
  );

  // Next state and per-state control outputs.
  always_comb begin
    state_d   = state_q;
    rop_d     = rop_q;
    timeout_d = timeout_q;
    illegal_c = 1'b0;
    ctrl_c    = '0;
    case (state_q)
      S_IF: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          ctrl_c.pc_we = 1'b1;
          ctrl_c.ir_we = 1'b1;
          state_d      = S_ID;
        end else if (expire_c) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_ID: begin
        case (opcode_c)
          OP_J, OP_JAL: begin
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.pc_src = PCSRC_JUMP;
            state_d       = S_IF;
            if (opcode_c == OP_JAL) begin
              ctrl_c.reg_we = 1'b1;
              ctrl_c.reg_in = 1'b1;
              ctrl_c.jal    = 1'b1;
            end
          end
          OP_BEQ, OP_BNE:        state_d = S_EX_BR;
          OP_LW, OP_SW, OP_ADDI: state_d = S_EX_MEMADDR;
          OP_XORI:               state_d = S_EX_XORI;
          OP_RTYPE: begin
            case (funct_c)
              FN_ADD: begin
                rop_d   = ALU_ADD;
                state_d = S_EX_RALU;
              end
              FN_SUB: begin
                rop_d   = ALU_SUB;
                state_d = S_EX_RALU;
              end
              FN_SLT: begin
                rop_d   = ALU_SLT;
                state_d = S_EX_RALU;
              end
              FN_JR:   state_d = S_EX_JR;
              default: illegal_c = 1'b1;
            endcase
          end
          default: illegal_c = 1'b1;
        endcase
        if (illegal_c) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_IF;
`endif
        end
      end
      S_EX_MEMADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
        case (opcode_c)
          OP_LW:   state_d = S_MEM_LW;
          OP_SW:   state_d = S_MEM_SW;
          default: state_d = S_WB_IMM;
        endcase
      end
      S_EX_XORI: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_XOR;
        state_d          = S_WB_IMM;
      end
      S_EX_RALU: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = rop_q;
        state_d          = S_WB_R;
      end
      S_EX_BR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.branch    = (opcode_c == OP_BNE) ? BR_BNE : BR_BEQ;
        state_d          = S_IF;
      end
      S_EX_JR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_JR;
        ctrl_c.pc_src    = PCSRC_ALU;
        ctrl_c.pc_we     = 1'b1;
        state_d          = S_IF;
      end
      S_MEM_LW: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_LW;
        end else if (expire_c) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_MEM_SW: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.mem_we = 1'b1;
          state_d       = S_IF;
        end else if (expire_c) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_WB_LW: begin
        ctrl_c.reg_we = 1'b1;
        state_d       = S_IF;
      end
      S_WB_IMM: begin
        ctrl_c.reg_we    = 1'b1;
        ctrl_c.reg_in    = 1'b1;
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        state_d          = S_IF;
      end
      S_WB_R: begin
        ctrl_c.reg_we    = 1'b1;
        ctrl_c.reg_in    = 1'b1;
        ctrl_c.dst       = 1'b1;
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        state_d          = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    // Nothing is driven while reset is held.
    if (!rst_n) begin
      ctrl_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      rop_q     <= ALU_ADD;
      retired_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rop_q     <= rop_d;
      timeout_q <= timeout_d;
      if ((state_d == S_IF) && (state_q != S_IF) && (state_q != S_HALT)) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign mem_req = ctrl_c.mem_req;
  assign PC_WE   = ctrl_c.pc_we;
  assign PCSrc   = ctrl_c.pc_src;
  assign MemIn   = ctrl_c.mem_in;
  assign Mem_WE  = ctrl_c.mem_we;
  assign IR_WE   = ctrl_c.ir_we;
  assign ALUSrcA = ctrl_c.alu_src_a;
  assign ALUSrcB = ctrl_c.alu_src_b;
  assign ALUop   = ctrl_c.alu_op;
  assign Dst     = ctrl_c.dst;
  assign RegIn   = ctrl_c.reg_in;
  assign Reg_WE  = ctrl_c.reg_we;
  assign Branch  = ctrl_c.branch;
  assign JAL     = ctrl_c.jal;
  assign retired = retired_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-instruction
// expectations, a negedge monitor pops and compares on each retirement.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned CNT_W    = 4;

  logic             clk;
  logic             rst_n;
  logic [31:0]      instruction;
  logic             mem_ready;
  logic             mem_req;
  logic             PC_WE;
  logic [1:0]       PCSrc;
  logic             MemIn;
  logic             Mem_WE;
  logic             IR_WE;
  logic             ALUSrcA;
  logic [2:0]       ALUSrcB;
  logic [2:0]       ALUop;
  logic             Dst;
  logic             RegIn;
  logic             Reg_WE;
  logic [3:0]       Branch;
  logic             JAL;
  logic [CNT_W-1:0] retired;
  logic             timeout;
  logic [4:0]       state_o;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .mem_req(mem_req), .PC_WE(PC_WE), .PCSrc(PCSrc), .MemIn(MemIn), .Mem_WE(Mem_WE),
    .IR_WE(IR_WE), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .Dst(Dst),
    .RegIn(RegIn), .Reg_WE(Reg_WE), .Branch(Branch), .JAL(JAL), .retired(retired),
    .timeout(timeout), .state_o(state_o)
  );

  typedef struct {
    int         lat;
    int         ir;
    int         pc;
    int         rw;
    int         dst;
    int         mw;
    int         alu;
    int         br;
    logic [3:0] ret;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] ret_model = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] ins(logic [5:0] op, logic [5:0] fn);
    return {op, 20'h4A5C3, fn};
  endfunction

  // Expected record for the next retiring instruction; IR_WE always pulses once.
  function automatic exp_t mk(int lat, int pc, int rw, int dst, int mw, int alu, int br);
    exp_t e;
    ret_model = ret_model + 4'd1;
    e.lat = lat; e.ir = 1; e.pc = pc; e.rw = rw; e.dst = dst;
    e.mw = mw; e.alu = alu; e.br = br; e.ret = ret_model;
    return e;
  endfunction

  // Monitor: accumulate per-instruction activity, compare on re-entry to IF.
  int         a_lat, a_ir, a_pc, a_rw, a_dst, a_mw, a_alu, a_br;
  logic [4:0] prev_st;
  exp_t       me;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_lat = 0; a_ir = 0; a_pc = 0; a_rw = 0; a_dst = 0; a_mw = 0; a_alu = 0; a_br = 0;
      prev_st = S_IF;
    end else begin
      if (state_o == S_IF && prev_st != S_IF && prev_st != S_HALT) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          me = sb.pop_front();
          check("lat", a_lat, me.lat);
          check("ir_we", a_ir, me.ir);
          check("pc_we", a_pc, me.pc);
          check("reg_we", a_rw, me.rw);
          check("dst", a_dst, me.dst);
          check("mem_we", a_mw, me.mw);
          check("aluop", a_alu, me.alu);
          check("branch", a_br, me.br);
          check("retired", 32'(retired), 32'(me.ret));
        end
        a_lat = 0; a_ir = 0; a_pc = 0; a_rw = 0; a_dst = 0; a_mw = 0; a_alu = 0; a_br = 0;
      end else if (state_o == S_HALT && prev_st != S_HALT) begin
        a_lat = 0; a_ir = 0; a_pc = 0; a_rw = 0; a_dst = 0; a_mw = 0; a_alu = 0; a_br = 0;
      end
      if (state_o != S_HALT) begin
        a_lat++;
        a_ir  += int'(IR_WE);
        a_pc  += int'(PC_WE);
        a_rw  += int'(Reg_WE);
        a_dst += int'(Reg_WE & Dst);
        a_mw  += int'(Mem_WE);
        if (ALUSrcB == 3'd2 && !Reg_WE) a_alu = a_alu | int'(ALUop);
        a_br = a_br | int'(Branch);
      end
      prev_st = state_o;
    end
  end

  // Runs one instruction from its IF cycle; memory answers after ifw/mw waits.
  task automatic exec(input logic [31:0] i, input int ifw, input int mw,
                      input exp_t e, input bit push);
    int         cnt;
    logic [4:0] prev;
    bit         left;
    bit         done;
    if (push) sb.push_back(e);
    instruction = i;
    cnt = 0; prev = state_o; left = 1'b0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (mem_req) mem_ready = (cnt >= ((state_o == S_IF) ? ifw : mw));
      else         mem_ready = 1'b1;
      @(posedge clk); #1;
      cnt  = (state_o == prev) ? cnt + 1 : 0;
      prev = state_o;
      if (state_o != S_IF) left = 1'b1;
      if ((left && state_o == S_IF) || state_o == S_HALT) done = 1'b1;
    end
    check("exec_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_we", 32'(PC_WE), 32'd0);
    check("rst_ir_we", 32'(IR_WE), 32'd0);
    rst_n = 1'b1;
    ret_model = '0;
    #1;
    check("rel_state", 32'(state_o), 32'(S_IF));
    check("rel_retired", 32'(retired), 32'd0);
    check("rel_timeout", 32'(timeout), 32'd0);
    check("rel_mem_req", 32'(mem_req), 32'd1);
    check("rel_srcb", 32'(ALUSrcB), 32'd3);
    check("rel_pcsrc", 32'(PCSrc), 32'd1);
  endtask

  exp_t dummy;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    instruction = '0;
    dummy = '{default: 0};
    do_reset();

    //               instr              ifw mw       lat pc rw dst mw alu br
    exec(ins(6'h00, 6'h20), 0, 0, mk(4, 1, 1, 1, 0, 0, 0), 1'b1);  // ADD
    exec(ins(6'h00, 6'h22), 0, 0, mk(4, 1, 1, 1, 0, 1, 0), 1'b1);  // SUB
    exec(ins(6'h00, 6'h2A), 0, 0, mk(4, 1, 1, 1, 0, 3, 0), 1'b1);  // SLT
    exec(ins(6'h02, 6'h2A), 0, 0, mk(2, 2, 0, 0, 0, 0, 0), 1'b1);  // J
    exec(ins(6'h03, 6'h00), 0, 0, mk(2, 2, 1, 0, 0, 0, 0), 1'b1);  // JAL
    exec(ins(6'h04, 6'h01), 0, 0, mk(3, 1, 0, 0, 0, 1, 1), 1'b1);  // BEQ
    exec(ins(6'h05, 6'h02), 0, 0, mk(3, 1, 0, 0, 0, 1, 2), 1'b1);  // BNE
    exec(ins(6'h00, 6'h08), 0, 0, mk(3, 2, 0, 0, 0, 0, 0), 1'b1);  // JR
    exec(ins(6'h08, 6'h20), 0, 0, mk(4, 1, 1, 0, 0, 0, 0), 1'b1);  // ADDI
    exec(ins(6'h0E, 6'h3F), 0, 0, mk(4, 1, 1, 0, 0, 0, 0), 1'b1);  // XORI
    exec(ins(6'h2B, 6'h10), 0, 0, mk(4, 1, 0, 0, 1, 0, 0), 1'b1);  // SW
    exec(ins(6'h23, 6'h04), 0, 0, mk(5, 1, 1, 0, 0, 0, 0), 1'b1);  // LW
    exec(ins(6'h23, 6'h04), 3, 2, mk(10, 1, 1, 0, 0, 0, 0), 1'b1); // LW with waits
    exec(ins(6'h2B, 6'h10), 0, 3, mk(7, 1, 0, 0, 1, 0, 0), 1'b1);  // SW, last legal wait
    exec(ins(6'h03, 6'h00), 3, 0, mk(5, 2, 1, 0, 0, 0, 0), 1'b1);  // JAL, IF waits

`ifdef MULTICYCLE_CTRL_TRAP_EN
    exec(ins(6'h3F, 6'h00), 0, 0, dummy, 1'b0);
    check("trap_state", 32'(state_o), 32'(S_HALT));
    check("trap_retired", 32'(retired), 32'(ret_model));
`else
    exec(ins(6'h3F, 6'h00), 0, 0, mk(2, 1, 0, 0, 0, 0, 0), 1'b1);
    check("nop_state", 32'(state_o), 32'(S_IF));
`endif
    do_reset();

    // Reset while a store is still waiting on memory.
    exec(ins(6'h00, 6'h20), 0, 0, mk(4, 1, 1, 1, 0, 0, 0), 1'b1);
    instruction = ins(6'h2B, 6'h11);
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("sw_wait_state", 32'(state_o), 32'(S_MEM_SW));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("swrst_state", 32'(state_o), 32'(S_IF));
    check("swrst_mem_we", 32'(Mem_WE), 32'd0);
    check("swrst_retired", 32'(retired), 32'd0);
    check("swrst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    ret_model = '0;
    #1;

    // Sixteen jumps wrap the 4-bit retired counter back to zero.
    for (int k = 0; k < 16; k++) begin
      exec(ins(6'h02, 6'h00), 0, 0, mk(2, 2, 0, 0, 0, 0, 0), 1'b1);
    end
    check("wrap_retired", 32'(retired), 32'd0);

    // Fetch never answered: times out after WAIT_MAX wait cycles.
    instruction = ins(6'h02, 6'h00);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_pre_timeout", 32'(timeout), 32'd0);
    check("to_pre_state", 32'(state_o), 32'(S_IF));
    @(posedge clk); #1;
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_state", 32'(state_o), 32'(S_HALT));
    check("to_mem_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("halt_state", 32'(state_o), 32'(S_HALT));
    check("halt_retired", 32'(retired), 32'd0);
    check("halt_pc_we", 32'(PC_WE), 32'd0);
    check("halt_ir_we", 32'(IR_WE), 32'd0);
    check("halt_timeout", 32'(timeout), 32'd1);

    do_reset();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
